muldiv_iter: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit that succeeds the ALU's fixed 32-bit divider hookup.

---
 rtl/muldiv_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: multi-cycle multiply/divide unit for the HILO path.
//
// Purpose
//   Executes MULT/MULTU/DIV/DIVU on WIDTH-bit operands and returns a
//   2*WIDTH-bit {hi,lo} result. Division is a radix-2 restoring divider on
//   operand magnitudes, one step per clock, with a sign fix at the end.
//   Division by zero bypasses the divider and completes right away.
//
// Ports
//   clk     in   1        rising-edge clock
//   rst     in   1        asynchronous, active-high reset
//   start   in   1        request, only sampled while idle
//   op      in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    in   WIDTH    operands, latched on an accepted start
//   annul   in   1        abort (exception flush), wins over everything
//   busy    out  1        operation in progress
//   ready   out  1        one-cycle pulse, result valid
//   div0    out  1        valid with ready: the division had b == 0
//   result  out  2*WIDTH  mult: product, div: {remainder, quotient}
//
// Build option
//   MULDIV_ITER_MUL_EN defined  : multiplies use a WIDTH-step shift-add in
//                                 the CALC state, so no multiplier is inferred.
//   MULDIV_ITER_MUL_EN undefined: multiplies use one combinational multiply
//                                 when start is accepted, then go to DONE.

module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 busy,
    output logic                 ready,
    output logic                 div0,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder / product high half
    logic [WIDTH-1:0]     quo_q, quo_d;   // dividend->quotient / multiplier->product low half
    logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor / multiplicand magnitude
    logic                 qneg_q, qneg_d; // negate quotient or product
    logic                 rneg_q, rneg_d; // negate remainder
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 div0_q, div0_d;
`ifdef MULDIV_ITER_MUL_EN
    logic                 is_mul_q, is_mul_d;
`else
    logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
`endif

    logic                 sgn_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       div_tmp, div_diff;
    logic [WIDTH-1:0]     rem_step, quo_step;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign busy   = (state_q != IDLE);
    assign ready  = ready_q;
    assign div0   = div0_q;
    assign result = result_q;

    always_comb begin
        // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
        // which still fits unsigned, so MIN/-1 falls out with no special case.
        sgn_op = ~op[0];
        abs_a  = cond_neg_w(a, sgn_op & a[WIDTH-1]);
        abs_b  = cond_neg_w(b, sgn_op & b[WIDTH-1]);

`ifndef MULDIV_ITER_MUL_EN
        // Width-extended operands make one multiplier serve both MULT and MULTU.
        ext_a = sgn_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b = sgn_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = ext_a * ext_b;
`endif

        // Restoring step: a negative trial difference (top bit set) restores.
        div_tmp  = {rem_q, quo_q[WIDTH-1]};
        div_diff = div_tmp - {1'b0, dvs_q};
        if (!div_diff[WIDTH]) begin
            rem_step = div_diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = div_tmp[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end

`ifdef MULDIV_ITER_MUL_EN
        // Shift-add step: add multiplicand when the multiplier LSB is set,
        // then shift the {carry, hi, lo} chain right by one.
        if (is_mul_q) begin
            div_tmp  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
            rem_step = div_tmp[WIDTH:1];
            quo_step = {div_tmp[0], quo_q[WIDTH-1:1]};
        end
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = 1'b0;
        div0_d   = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
        is_mul_d = is_mul_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    cnt_d  = '0;
                    qneg_d = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d = sgn_op & a[WIDTH-1];
                    rem_d  = '0;
                    if (op[1]) begin
                        if (b == '0) begin
                            result_d = {a, {WIDTH{1'b1}}};
                            ready_d  = 1'b1;
                            div0_d   = 1'b1;
                            state_d  = DONE;
                        end else begin
                            quo_d   = abs_a;
                            dvs_d   = abs_b;
                            state_d = CALC;
                        end
`ifdef MULDIV_ITER_MUL_EN
                        is_mul_d = 1'b0;
                    end else begin
                        quo_d    = abs_b;
                        dvs_d    = abs_a;
                        is_mul_d = 1'b1;
                        state_d  = CALC;
                    end
`else
                    end else begin
                        result_d = prod;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
`ifdef MULDIV_ITER_MUL_EN
                    if (is_mul_q)
                        result_d = cond_neg_2w({rem_step, quo_step}, qneg_q);
                    else
`endif
                        result_d = {cond_neg_w(rem_step, rneg_q), cond_neg_w(quo_step, qneg_q)};
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort: no result write, no ready pulse, back to IDLE.
        if (annul) begin
            state_d  = IDLE;
            result_d = result_q;
            ready_d  = 1'b0;
            div0_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            div0_q   <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
            is_mul_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            div0_q   <= div0_d;
`ifdef MULDIV_ITER_MUL_EN
            is_mul_q <= is_mul_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors with hand-computed results for muldiv_iter
// (WIDTH=32). Expected multiply latency follows MULDIV_ITER_MUL_EN.

module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        annul = 1'b0;
    logic        busy, ready, div0;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_N = 32;
`else
    localparam int MUL_N = 0;
`endif

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .annul(annul), .busy(busy), .ready(ready), .div0(div0), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, then scramble the operand inputs. Optionally
    // pulse a (to-be-ignored) start while busy. Checks latency, result,
    // div0 and the return to idle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input int exp_n, input logic [63:0] exp_res,
                         input logic exp_d0, input bit poke);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!ready && n < 100) begin
            if (poke && n == 3) begin
                start = 1'b1; op = DIVU; a = 32'd5; b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(exp_n));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_div0"}, 64'(div0), 64'(exp_d0));
        @(posedge clk); #1;
        chk({tag, "_rdy_off"}, 64'(ready), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [63:0] held;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32, {32'd2, 32'd14}, 1'b0, 1'b1);
        do_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0);
        do_op("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32, {32'h0, 32'h80000000}, 1'b0, 1'b0);
        do_op("divu_5_0", DIVU, 32'd5, 32'd0, 0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1'b0);
        do_op("div_m9_0", DIV, 32'hFFFFFFF7, 32'd0, 0, {32'hFFFFFFF7, 32'hFFFFFFFF}, 1'b1, 1'b0);
        do_op("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32, {32'd1, 32'hFFFFFFFD}, 1'b0, 1'b0);
        do_op("div_m100_m7", DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32, {32'hFFFFFFFE, 32'd14}, 1'b0, 1'b0);
        do_op("divu_max_1", DIVU, 32'hFFFFFFFF, 32'd1, 32, {32'd0, 32'hFFFFFFFF}, 1'b0, 1'b0);
        do_op("mult_m3_5", MULT, 32'hFFFFFFFD, 32'd5, MUL_N, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b0);
        do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_N, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
        do_op("mult_min_min", MULT, 32'h80000000, 32'h80000000, MUL_N, 64'h40000000_00000000, 1'b0, 1'b0);
        do_op("mult_12345_m1", MULT, 32'd12345, 32'hFFFFFFFF, MUL_N, 64'hFFFFFFFF_FFFFCFC7, 1'b0, 1'b0);

        // Annul DIV 9/2: annul sampled at edge 11, start alongside it dropped
        held = result;
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("annul_busy_e10", 64'(busy), 64'd1);
        annul = 1'b1; start = 1'b1; op = DIVU; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        chk("annul_busy_e11", 64'(busy), 64'd0);
        chk("annul_rdy_e11", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("annul_start_drop", 64'(busy), 64'd0);
        annul = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        chk("annul_no_ready", 64'(pulses), 64'd0);
        chk("annul_result_held", result, held);
        do_op("div_9_2", DIV, 32'd9, 32'd2, 32, {32'd1, 32'd4}, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("multu_6_7", MULTU, 32'd6, 32'd7, MUL_N, 64'd42, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
